// File: rtl/pwm_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// pwm_cmd_dispatch
//
// Purpose:
//   Takes fully assembled command frames (already in the fpga_clock domain),
//   checks them with a bit-serial CRC-4 (x^4+x+1, init 0, MSB first), decodes
//   individual / group / broadcast addressing and writes per-channel PWM
//   targets. Each written channel raises a pwm_update flag that stays up until
//   the PWM generator acknowledges it with pwm_done. CRC failures and frames
//   that land on still-pending channels are counted (saturating) for software.
//
// Frame layout, MSB first:
//   mode[1:0] | sel[SEL_W-1:0] | data[DATA_W-1:0] | crc[3:0]
//   mode 00 = individual (channel = sel)
//   mode 01 = group      (channels sel*GROUP_SIZE .. +GROUP_SIZE-1)
//   mode 10 = broadcast  (all channels, sel ignored)
//   mode 11 = reserved   (address error)
//
// Ports:
//   fpga_clock     in   1                 sole clock, rising edge
//   reset          in   1                 synchronous, active-high reset
//   frame          in   FRAME_W           command frame
//   frame_valid    in   1                 frame is present
//   frame_ready    out  1                 block can accept a frame (IDLE only)
//   pwm_done       in   NUM_CH            per-channel acknowledge
//   pwm_target     out  NUM_CH*DATA_W     channel i at [i*DATA_W +: DATA_W]
//   pwm_update     out  NUM_CH            per-channel new-target-pending flag
//   crc_error      out  1                 one-cycle pulse on CRC mismatch
//   addr_error     out  1                 one-cycle pulse on bad mode/selector
//   crc_err_count  out  8                 saturating CRC error count
//   overrun_count  out  8                 saturating overrun frame count
//
// Timing:
//   Accepting edge = edge 0. The payload is shifted through the CRC on edges
//   1..PAYLOAD_W, the verdict is taken in the following cycle and all outputs
//   change on edge PAYLOAD_W+1, the same edge on which frame_ready rises again.
// -----------------------------------------------------------------------------
module pwm_cmd_dispatch #(
    parameter  int NUM_CH     = 12,
    parameter  int DATA_W     = 8,
    parameter  int GROUP_SIZE = 4,
    parameter  int SEL_W      = 4,
    localparam int FRAME_W    = 2 + SEL_W + DATA_W + 4
) (
    input  logic                       fpga_clock,
    input  logic                       reset,
    input  logic [FRAME_W-1:0]         frame,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic [NUM_CH-1:0]          pwm_done,
    output logic [NUM_CH*DATA_W-1:0]   pwm_target,
    output logic [NUM_CH-1:0]          pwm_update,
    output logic                       crc_error,
    output logic                       addr_error,
    output logic [7:0]                 crc_err_count,
    output logic [7:0]                 overrun_count
);

    localparam int NUM_GROUPS = NUM_CH / GROUP_SIZE;
    localparam int PAYLOAD_W  = FRAME_W - 4;
    localparam int CNT_W      = $clog2(PAYLOAD_W);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_W - 1);
    localparam logic [3:0]       CRC_POLY = 4'b0011;   // x^4 + x + 1, x^4 implicit

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CRC     = 2'd1,
        S_VERDICT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_INDIV = 2'b00,
        M_GROUP = 2'b01,
        M_BCAST = 2'b10,
        M_RSVD  = 2'b11
    } mode_e;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    state_e state_q, state_d;

    logic accept;
    logic shift_en;
    logic verdict_en;
    logic last_bit;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in a combinational process receives a default
    // at the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept)   state_d = S_CRC;
            S_CRC:     if (last_bit) state_d = S_VERDICT;
            S_VERDICT:               state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        frame_ready = 1'b0;
        shift_en    = 1'b0;
        verdict_en  = 1'b0;
        case (state_q)
            // Ready is gated by reset directly so it is low for the whole reset
            // window, including the first cycle of reset from a busy state.
            S_IDLE:    frame_ready = ~reset;
            S_CRC:     shift_en    = 1'b1;
            S_VERDICT: verdict_en  = 1'b1;
            default:   ;
        endcase
    end

    assign accept = frame_valid & frame_ready;

    // -------------------------------------------------------------------------
    // Frame holding register and serial CRC engine
    // -------------------------------------------------------------------------
    logic [FRAME_W-1:0]   frame_q;
    logic [PAYLOAD_W-1:0] shift_q;     // payload, consumed from the MSB end
    logic [3:0]           crc_q;
    logic [3:0]           crc_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 crc_fb;

    assign last_bit = (cnt_q == LAST_BIT);

    always_comb begin
        crc_fb = crc_q[3] ^ shift_q[PAYLOAD_W-1];
        crc_d  = {crc_q[2:0], 1'b0} ^ (crc_fb ? CRC_POLY : 4'b0000);
    end

    // NOTE: these datapath registers are deliberately not reset: each one is
    // loaded on the accepting edge before any state reads it, so a reset term
    // would only add fan-out on the reset net.
    always_ff @(posedge fpga_clock) begin
        if (accept) begin
            frame_q <= frame;
            shift_q <= frame[FRAME_W-1:4];
            crc_q   <= 4'b0000;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shift_q <= shift_q << 1;
            crc_q   <= crc_d;
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Field decode and verdict
    // -------------------------------------------------------------------------
    mode_e             mode_f;
    logic [SEL_W-1:0]  sel_f;
    logic [DATA_W-1:0] data_f;
    logic [3:0]        crc_f;
    int                sel_int;

    assign mode_f  = mode_e'(frame_q[FRAME_W-1 -: 2]);
    assign sel_f   = frame_q[FRAME_W-3 -: SEL_W];
    assign data_f  = frame_q[4 +: DATA_W];
    assign crc_f   = frame_q[3:0];
    assign sel_int = int'(sel_f);

    logic [NUM_CH-1:0] sel_mask;
    logic              addr_bad;
    logic              crc_bad;

    always_comb begin
        sel_mask = '0;
        addr_bad = 1'b0;
        case (mode_f)
            M_INDIV: begin
                addr_bad = (sel_int >= NUM_CH);
                for (int i = 0; i < NUM_CH; i++) begin
                    sel_mask[i] = (i == sel_int);
                end
            end
            M_GROUP: begin
                addr_bad = (sel_int >= NUM_GROUPS);
                for (int i = 0; i < NUM_CH; i++) begin
                    sel_mask[i] = ((i / GROUP_SIZE) == sel_int);
                end
            end
            M_BCAST: sel_mask = '1;
            default: addr_bad = 1'b1;   // reserved mode
        endcase
    end

    assign crc_bad = (crc_q != crc_f);

    // -------------------------------------------------------------------------
    // Output state: targets, update flags, error pulses, counters
    // -------------------------------------------------------------------------
    logic [NUM_CH*DATA_W-1:0] target_q, target_d;
    logic [NUM_CH-1:0]        upd_q, upd_d;
    logic [NUM_CH-1:0]        apply_mask;
    logic                     apply;
    logic                     overrun;
    logic                     crc_err_q, crc_err_d;
    logic                     addr_err_q, addr_err_d;
    logic [7:0]               crc_cnt_q, crc_cnt_d;
    logic [7:0]               ovr_cnt_q, ovr_cnt_d;

    always_comb begin
        // CRC failure outranks address failure, so at most one pulse fires.
        crc_err_d  = verdict_en & crc_bad;
        addr_err_d = verdict_en & ~crc_bad & addr_bad;
        apply      = verdict_en & ~crc_bad & ~addr_bad;
        apply_mask = apply ? sel_mask : '0;

        // Overrun: the frame hits at least one channel whose previous target
        // has not been acknowledged yet; the new value simply replaces it.
        overrun    = |(apply_mask & upd_q);

        target_d = target_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (apply_mask[i]) begin
                target_d[i*DATA_W +: DATA_W] = data_f;
            end
        end

        // Acknowledge clears only pending bits; a same-edge apply wins.
        upd_d = (upd_q & ~pwm_done) | apply_mask;

        crc_cnt_d = (crc_err_d && crc_cnt_q != 8'hFF) ? crc_cnt_q + 8'd1 : crc_cnt_q;
        ovr_cnt_d = (overrun   && ovr_cnt_q != 8'hFF) ? ovr_cnt_q + 8'd1 : ovr_cnt_q;
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            target_q   <= '0;
            upd_q      <= '0;
            crc_err_q  <= 1'b0;
            addr_err_q <= 1'b0;
            crc_cnt_q  <= 8'd0;
            ovr_cnt_q  <= 8'd0;
        end else begin
            target_q   <= target_d;
            upd_q      <= upd_d;
            crc_err_q  <= crc_err_d;
            addr_err_q <= addr_err_d;
            crc_cnt_q  <= crc_cnt_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    assign pwm_target    = target_q;
    assign pwm_update    = upd_q;
    assign crc_error     = crc_err_q;
    assign addr_error    = addr_err_q;
    assign crc_err_count = crc_cnt_q;
    assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_pwm_cmd_dispatch.sv
// -----------------------------------------------------------------------------
// tb_pwm_cmd_dispatch
//
// Directed bench for pwm_cmd_dispatch at default parameters (12 channels,
// 8-bit targets, groups of 4, 4-bit selector, 18-bit frames). Inputs are
// driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_cmd_dispatch;

    localparam int NUM_CH  = 12;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 18;

    logic                     fpga_clock;
    logic                     reset;
    logic [FRAME_W-1:0]       frame;
    logic                     frame_valid;
    logic                     frame_ready;
    logic [NUM_CH-1:0]        pwm_done;
    logic [NUM_CH*DATA_W-1:0] pwm_target;
    logic [NUM_CH-1:0]        pwm_update;
    logic                     crc_error;
    logic                     addr_error;
    logic [7:0]               crc_err_count;
    logic [7:0]               overrun_count;

    pwm_cmd_dispatch dut (
        .fpga_clock    (fpga_clock),
        .reset         (reset),
        .frame         (frame),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .pwm_done      (pwm_done),
        .pwm_target    (pwm_target),
        .pwm_update    (pwm_update),
        .crc_error     (crc_error),
        .addr_error    (addr_error),
        .crc_err_count (crc_err_count),
        .overrun_count (overrun_count)
    );

    initial fpga_clock = 1'b0;
    always #5 fpga_clock = ~fpga_clock;

    int tests_run;
    int tests_failed;

    logic [NUM_CH*DATA_W-1:0] exp_t;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clock);
        #1;
    endtask

    // Reference CRC-4, x^4+x+1, init 0, MSB first over the 14-bit payload.
    function automatic logic [3:0] crc4(input logic [13:0] p);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 13; i >= 0; i--) begin
            fb = c[3] ^ p[i];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    function automatic logic [17:0] mk(input logic [1:0] m, input logic [3:0] s,
                                       input logic [7:0] d);
        logic [13:0] p;
        p = {m, s, d};
        return {p, crc4(p)};
    endfunction

    // Present a frame and complete the accepting edge (edge 0).
    task automatic send(input logic [17:0] f);
        int n;
        frame       = f;
        frame_valid = 1'b1;
        n = 0;
        while (!frame_ready && n < 40) begin
            tick();
            n++;
        end
        check("ready_before_accept", frame_ready, 1'b1);
        tick();
        frame_valid = 1'b0;
    endtask

    // Send and advance to the edge where the verdict becomes visible.
    task automatic run_frame(input logic [17:0] f);
        send(f);
        repeat (15) tick();
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        exp_t[ch*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        int hit_pos [3];
        logic seen;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        frame        = '0;
        frame_valid  = 1'b0;
        pwm_done     = '0;
        exp_t        = '0;
        hits         = 0;
        seen         = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_ready",    frame_ready,   1'b0);
        check("rst_target",   pwm_target,    '0);
        check("rst_update",   pwm_update,    '0);
        check("rst_crc_err",  crc_error,     1'b0);
        check("rst_addr_err", addr_error,    1'b0);
        check("rst_crc_cnt",  crc_err_count, 8'd0);
        check("rst_ovr_cnt",  overrun_count, 8'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", frame_ready, 1'b1);

        // ---------------- broadcast 0x57 ----------------
        send(18'h2057F);
        repeat (14) tick();
        check("bc_pre_update", pwm_update,  12'h000);
        check("bc_pre_ready",  frame_ready, 1'b0);
        check("bc_pre_target", pwm_target,  '0);
        tick();
        exp_t = {NUM_CH{8'h57}};
        check("bc_target",   pwm_target,  exp_t);
        check("bc_update",   pwm_update,  12'hFFF);
        check("bc_crc_err",  crc_error,   1'b0);
        check("bc_addr_err", addr_error,  1'b0);
        check("bc_ready",    frame_ready, 1'b1);
        pwm_done = 12'h00F;
        tick();
        check("done_lo", pwm_update, 12'hFF0);
        pwm_done = 12'hFF0;
        tick();
        check("done_hi", pwm_update, 12'h000);
        pwm_done = 12'h000;

        // ---------------- CRC error ----------------
        run_frame(18'h2057E);
        check("crc_pulse",    crc_error,     1'b1);
        check("crc_no_addr",  addr_error,    1'b0);
        check("crc_cnt1",     crc_err_count, 8'd1);
        check("crc_target",   pwm_target,    exp_t);
        check("crc_update",   pwm_update,    12'h000);
        check("crc_ready",    frame_ready,   1'b1);
        tick();
        check("crc_pulse_end", crc_error, 1'b0);

        // ---------------- group 1 ----------------
        run_frame(mk(2'b01, 4'd1, 8'h3C));
        for (int c = 4; c < 8; c++) set_ch(c, 8'h3C);
        check("grp_target", pwm_target, exp_t);
        check("grp_update", pwm_update, 12'h0F0);
        pwm_done = 12'h0F0;
        tick();
        pwm_done = 12'h000;

        // ---------------- individual 8 ----------------
        run_frame(mk(2'b00, 4'd8, 8'hA5));
        set_ch(8, 8'hA5);
        check("ind_target", pwm_target, exp_t);
        check("ind_update", pwm_update, 12'h100);
        pwm_done = 12'h100;
        tick();
        pwm_done = 12'h000;

        // ---------------- address errors ----------------
        run_frame(mk(2'b00, 4'd12, 8'hEE));
        check("ind12_addr", addr_error, 1'b1);
        check("ind12_crc",  crc_error,  1'b0);
        tick();
        check("ind12_pulse_end", addr_error, 1'b0);
        run_frame(mk(2'b01, 4'd3, 8'hEE));
        check("grp3_addr", addr_error, 1'b1);
        run_frame(mk(2'b11, 4'd0, 8'hEE));
        check("mode11_addr", addr_error, 1'b1);
        check("addr_target", pwm_target, exp_t);
        check("addr_update", pwm_update, 12'h000);
        check("addr_crc_cnt", crc_err_count, 8'd1);

        // ---------------- overrun + collision ----------------
        run_frame(mk(2'b01, 4'd0, 8'h11));
        for (int c = 0; c < 4; c++) set_ch(c, 8'h11);
        check("ovr_first_update", pwm_update,    12'h00F);
        check("ovr_first_cnt",    overrun_count, 8'd0);
        send(mk(2'b01, 4'd0, 8'h22));
        repeat (14) tick();
        pwm_done = 12'h001;      // acknowledge lands on the apply edge
        tick();
        pwm_done = 12'h000;
        for (int c = 0; c < 4; c++) set_ch(c, 8'h22);
        check("ovr_update", pwm_update,    12'h00F);
        check("ovr_cnt",    overrun_count, 8'd1);
        check("ovr_target", pwm_target,    exp_t);
        pwm_done = 12'h00F;
        tick();
        pwm_done = 12'h000;
        check("ovr_cleared", pwm_update, 12'h000);

        // ---------------- backpressure ----------------
        frame       = mk(2'b00, 4'd0, 8'h77);
        frame_valid = 1'b1;
        for (int k = 0; k < 48; k++) begin
            if (frame_ready) begin
                if (hits < 3) hit_pos[hits] = k;
                hits++;
            end
            tick();
        end
        frame_valid = 1'b0;
        check("bp_hits", hits, 3);
        check("bp_pos0", hit_pos[0], 0);
        check("bp_pos1", hit_pos[1], 16);
        check("bp_pos2", hit_pos[2], 32);
        set_ch(0, 8'h77);
        check("bp_target",  pwm_target,    exp_t);
        check("bp_update",  pwm_update,    12'h001);
        check("bp_ovr_cnt", overrun_count, 8'd3);
        pwm_done = 12'h001;
        tick();
        pwm_done = 12'h000;

        // ---------------- reset mid-CRC ----------------
        send(mk(2'b01, 4'd2, 8'h99));
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_target",  pwm_target,    '0);
        check("mid_rst_update",  pwm_update,    '0);
        check("mid_rst_crc_cnt", crc_err_count, 8'd0);
        check("mid_rst_ovr_cnt", overrun_count, 8'd0);
        check("mid_rst_ready",   frame_ready,   1'b0);
        check("mid_rst_pulses",  {crc_error, addr_error}, 2'b00);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (crc_error || addr_error || pwm_update != '0) seen = 1'b1;
        end
        check("mid_rst_no_effect", seen, 1'b0);
        exp_t = '0;
        run_frame(mk(2'b00, 4'd3, 8'h5A));
        set_ch(3, 8'h5A);
        check("post_rst_target", pwm_target, exp_t);
        check("post_rst_update", pwm_update, 12'h008);

        // ---------------- saturation ----------------
        for (int n = 1; n <= 260; n++) begin
            run_frame(18'h2057E);
            if (n == 200) check("sat_200", crc_err_count, 8'd200);
        end
        check("sat_255", crc_err_count, 8'd255);
        check("sat_target", pwm_target, exp_t);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pwm_cmd_dispatch.md
Name: pwm_cmd_dispatch

Overview:
- Parametrised successor to the 12-channel PWM address decoder.
- Accepts fully assembled command frames, already in the fpga_clock domain, from the SPI front end, and checks them with a serial CRC-4.
- Decodes individual, group or broadcast addressing, then writes per-channel PWM targets.
- Drives a per-channel pwm_update/pwm_done handshake to the PWM generators, with error and overrun counters for software diagnostics.

Parameters:
- NUM_CH, 12, number of PWM channels.
- DATA_W, 8, width of each PWM target.
- GROUP_SIZE, 4, channels per group; NUM_CH must be a multiple of GROUP_SIZE. NUM_GROUPS = NUM_CH/GROUP_SIZE.
- SEL_W, 4, selector field width; 2^SEL_W >= NUM_CH.

Ports:
- fpga_clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- frame  in  FRAME_W  command frame; FRAME_W = 2+SEL_W+DATA_W+4.
- frame_valid  in  1  frame is present.
- frame_ready  out  1  block can accept a frame.
- pwm_done  in  NUM_CH  per-channel acknowledge from the PWM generators.
- pwm_target  out  NUM_CH*DATA_W  channel i target at [i*DATA_W +: DATA_W].
- pwm_update  out  NUM_CH  per-channel new-target-pending flag.
- crc_error  out  1  one-cycle pulse on CRC mismatch.
- addr_error  out  1  one-cycle pulse on invalid mode or selector.
- crc_err_count  out  8  saturating count of CRC errors.
- overrun_count  out  8  saturating count of overrun frames.

Behaviour:
- Frame fields, MSB first: mode[1:0], sel[SEL_W-1:0], data[DATA_W-1:0], crc[3:0]. The payload is everything above crc; PAYLOAD_W = FRAME_W-4.
- Modes:
  - 00: individual; channel = sel.
  - 01: group; channels sel*GROUP_SIZE .. sel*GROUP_SIZE+GROUP_SIZE-1.
  - 10: broadcast; all channels, sel ignored.
  - 11: reserved.
- CRC-4:
  - Polynomial x^4+x+1, init 0, MSB first, one payload bit per cycle.
  - Per bit: fb = c[3]^b; c = {c[2:0],0} ^ (fb ? 4'b0011 : 0).
- Handshake:
  - A frame is accepted on an edge where frame_valid && frame_ready; the frame is captured into a holding register.
  - frame_ready = 1 only in IDLE and not during reset. The source must hold the frame until it is accepted.
- FSM:
  - IDLE: on accept, go to CRC; bit counter = 0; crc = 0.
  - CRC: shift one payload bit per cycle for PAYLOAD_W cycles, then go to VERDICT.
  - VERDICT: one cycle, then return to IDLE. Actions, in priority order:
    - CRC mismatch: pulse crc_error, increment crc_err_count.
    - Otherwise, mode 11, individual sel >= NUM_CH, or group sel >= NUM_GROUPS: pulse addr_error.
    - Otherwise, apply the frame: write data to each selected pwm_target and set its pwm_update bit.
- Latency:
  - Outputs change on the edge ending VERDICT, PAYLOAD_W+1 edges after the accepting edge (15 at defaults).
  - frame_ready rises on that same edge. Throughput is one frame per PAYLOAD_W+2 cycles.
- Update handshake:
  - pwm_update[i] clears on any edge where pwm_update[i] && pwm_done[i].
  - If an apply sets bit i on the same edge that pwm_done[i] is high, the set wins.
  - pwm_done[i] while pwm_update[i] = 0 is ignored.
- Overrun:
  - An applied frame whose selected set contains any channel with pwm_update already 1 increments overrun_count by one per frame.
  - The new data still overwrites the target and update stays 1 (coalesced).
- Counters: 8 bits, saturating at 255, never wrap. They are cleared only by reset.
- Error pulses: crc_error and addr_error are high for exactly one cycle and never both in the same cycle.
- Reset values: frame_ready 0 while reset is high, 1 on the first cycle after. pwm_target all 0, pwm_update 0, crc_error 0, addr_error 0, counters 0. FSM goes to IDLE.
- Reset mid-frame: the in-flight frame is abandoned with no target write, no pulse and no count.

Test Plan:
- Broadcast: frame 18'h2057F (mode 10, data 0x57, crc 0xF) accepted → 15 edges later every target = 0x57, pwm_update = 12'hFFF, crc_error stays 0. Then pwm_done = 12'h00F → pwm_update = 12'hFF0 next edge. Then pwm_done = 12'hFF0 → pwm_update = 0.
- CRC error: frame 18'h2057E → one-cycle crc_error pulse, crc_err_count = 1, targets and pwm_update unchanged, frame_ready high again.
- Group / individual with correct CRC:
  - Group sel 1, data 0x3C → only targets 4..7 = 0x3C and pwm_update = 12'h0F0.
  - Individual sel 8, data 0xA5 → only bit 8 set.
  - Individual sel 12 → addr_error pulse, no change.
- Overrun and collision: repeat a group-0 write before pwm_done → overrun_count = 1, target holds the new value. Assert pwm_done[0] on the apply edge → pwm_update[0] stays 1.
- Saturation: 260 bad-CRC frames → crc_err_count = 255.
- Reset: assert reset mid-CRC → all outputs zero, no pulse. The next good frame applies normally.
- Backpressure: hold frame_valid high continuously → acceptance every 16 cycles, frame_ready low throughout CRC and VERDICT.
